// File: rtl/freq_gen_pkg.sv
// -----------------------------------------------------------------------------
// freq_gen_pkg
// Shared definitions for the frequency generator:
//   state_t  - control FSM states (IDLE, CALC, LOAD)
//   half_of  - integer halving, used to derive the highest legal request
//              (CLK_FREQ_HZ/2) as an elaboration-time constant
// -----------------------------------------------------------------------------
package freq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        LOAD = 2'd2
    } state_t;

    function automatic logic [31:0] half_of(input logic [31:0] value);
        return value >> 1;
    endfunction

endpackage

// File: rtl/tuning_word_divider.sv
// -----------------------------------------------------------------------------
// tuning_word_divider
// Sequential restoring divider computing
//   quotient = floor(dividend * 2^WIDTH / DIVISOR)
// one quotient bit per cycle, MSB first, WIDTH iterations per request.
// Ports:
//   Clk      in   system clock
//   Rst      in   synchronous active-high reset
//   start    in   load dividend and begin a division
//   dividend in   32-bit dividend (requested frequency in Hz)
//   busy     out  division in progress
//   done     out  high during the final iteration; quotient is complete
//                 after the clock edge that ends this cycle
//   quotient out  WIDTH-bit result
// -----------------------------------------------------------------------------
module tuning_word_divider #(
    parameter int unsigned DIVISOR = 100_000_000,
    parameter int unsigned WIDTH   = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [31:0]      dividend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    // Remainder is at least WIDTH+1 bits; it also has to hold 2*(DIVISOR-1),
    // which needs 33 bits when the divisor uses all 32 bits.
    localparam int unsigned RW = ((WIDTH + 1) > 33) ? (WIDTH + 1) : 33;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [RW-1:0]    r_rem;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic [WIDTH-1:0] r_quot;

    logic [RW-1:0]    w_divisor;
    logic [RW-1:0]    w_shifted;
    logic             w_bit;
    logic             w_last;

    assign w_divisor = RW'(DIVISOR);
    assign w_shifted = {r_rem[RW-2:0], 1'b0};
    assign w_bit     = (w_shifted >= w_divisor);
    assign w_last    = r_busy && (r_count == CW'(WIDTH - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rem   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_quot  <= '0;
        end else if (start) begin
            r_rem   <= RW'(dividend);
            r_count <= '0;
            r_busy  <= 1'b1;
            r_quot  <= '0;
        end else if (r_busy) begin
            r_rem   <= w_bit ? (w_shifted - w_divisor) : w_shifted;
            r_quot  <= {r_quot[WIDTH-2:0], w_bit};
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = w_last;
    assign quotient = r_quot;

endmodule

// File: rtl/frequency_generator.sv
// -----------------------------------------------------------------------------
// frequency_generator
// Programmable square-wave source. A requested frequency (Hz) is accepted over
// a valid/ready handshake, range-checked against CLK_FREQ_HZ/2, converted into
// a phase-accumulator tuning word by a sequential divider, and used to drive a
// registered 50 %-duty square wave on Fxout.
// Ports:
//   Clk          in   system clock (only clock)
//   Rst          in   synchronous active-high reset
//   Enable       in   1 = accumulator runs, 0 = accumulator/Fxout held at 0
//   Freq_Set     in   requested frequency in Hz
//   Set_Valid    in   Freq_Set is valid
//   Set_Ready    out  request can be accepted (IDLE only)
//   Set_Err      out  one-cycle pulse after an out-of-range request
//   Tuning_Word  out  active tuning word
//   Fxout        out  generated square wave
// -----------------------------------------------------------------------------
module frequency_generator
    import freq_gen_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned ACC_WIDTH   = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Enable,
    input  logic [31:0]          Freq_Set,
    input  logic                 Set_Valid,
    output logic                 Set_Ready,
    output logic                 Set_Err,
    output logic [ACC_WIDTH-1:0] Tuning_Word,
    output logic                 Fxout
);

    localparam logic [31:0] MAX_FREQ = half_of(32'(CLK_FREQ_HZ));

    state_t                 r_state;
    state_t                 w_next_state;

    logic                   r_set_err;
    logic [ACC_WIDTH-1:0]   r_tuning_word;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_fxout;

    logic                   w_ready;
    logic                   w_handshake;
    logic                   w_in_range;
    logic                   w_accept;
    logic                   w_div_busy;
    logic                   w_div_done;
    logic [ACC_WIDTH-1:0]   w_quotient;

    // The divider is always idle by the time the FSM is back in IDLE; the
    // busy term only guards against accepting a request over a running division.
    assign w_ready     = (r_state == IDLE) && !w_div_busy;
    assign w_handshake = Set_Valid && w_ready;
    assign w_in_range  = (Freq_Set <= MAX_FREQ);
    assign w_accept    = w_handshake && w_in_range;

    tuning_word_divider #(
        .DIVISOR (CLK_FREQ_HZ),
        .WIDTH   (ACC_WIDTH)
    ) u_divider (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (w_accept),
        .dividend (Freq_Set),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)   w_next_state = CALC;
            CALC:    if (w_div_done) w_next_state = LOAD;
            LOAD:                    w_next_state = IDLE;
            default:                 w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_set_err     <= 1'b0;
            r_tuning_word <= '0;
        end else begin
            r_set_err <= w_handshake && !w_in_range;
            if (r_state == LOAD) begin
                r_tuning_word <= w_quotient;
            end
        end
    end

    // Fxout takes the MSB before the add, so it lags the accumulator by a
    // cycle. A new tuning word does not clear the phase.
    always_ff @(posedge Clk) begin
        if (Rst || !Enable || (r_tuning_word == '0)) begin
            r_acc   <= '0;
            r_fxout <= 1'b0;
        end else begin
            r_fxout <= r_acc[ACC_WIDTH-1];
            r_acc   <= r_acc + r_tuning_word;
        end
    end

    assign Set_Ready   = w_ready;
    assign Set_Err     = r_set_err;
    assign Tuning_Word = r_tuning_word;
    assign Fxout       = r_fxout;

endmodule

// File: tb/tb_frequency_generator.sv
// -----------------------------------------------------------------------------
// tb_frequency_generator
// Directed self-checking bench for frequency_generator (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_frequency_generator;

    logic        Clk;
    logic        Rst;
    logic        Enable;
    logic [31:0] Freq_Set;
    logic        Set_Valid;
    logic        Set_Ready;
    logic        Set_Err;
    logic [31:0] Tuning_Word;
    logic        Fxout;

    int n_tests = 0;
    int n_fail  = 0;

    frequency_generator #(
        .CLK_FREQ_HZ (100_000_000),
        .ACC_WIDTH   (32)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Enable      (Enable),
        .Freq_Set    (Freq_Set),
        .Set_Valid   (Set_Valid),
        .Set_Ready   (Set_Ready),
        .Set_Err     (Set_Err),
        .Tuning_Word (Tuning_Word),
        .Fxout       (Fxout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [63:0] obs,
                               input logic [63:0] lo, input logic [63:0] hi);
        n_tests++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Called on a falling edge while Set_Ready is high; returns on the falling
    // edge of the first cycle after the handshake.
    task automatic send(input logic [31:0] f);
        Freq_Set  = f;
        Set_Valid = 1'b1;
        tick(1);
        Set_Valid = 1'b0;
    endtask

    initial begin
        int   t0;
        int   t1;
        int   rises;
        logic prev;
        logic [7:0] pat;

        Rst       = 1'b1;
        Enable    = 1'b0;
        Set_Valid = 1'b0;
        Freq_Set  = '0;
        tick(3);
        check("rst_ready", Set_Ready, 1);
        check("rst_err", Set_Err, 0);
        check("rst_tw", Tuning_Word, 0);
        check("rst_fx", Fxout, 0);
        Rst    = 1'b0;
        Enable = 1'b1;
        tick(1);

        // 1 MHz: Q = floor(2^32/100) = 42_949_672
        send(32'd1_000_000);
        check("err_1M", Set_Err, 0);
        check("ready_calc", Set_Ready, 0);
        tick(32);
        check("tw_in_load", Tuning_Word, 0);
        check("ready_load", Set_Ready, 0);
        tick(1);
        check("tw_1M", Tuning_Word, 42_949_672);
        check("ready_back", Set_Ready, 1);

        t0 = -1;
        t1 = -1;
        for (int c = 0; c < 400 && t1 < 0; c++) begin
            prev = Fxout;
            tick(1);
            if (!prev && Fxout) begin
                if (t0 < 0) t0 = c;
                else        t1 = c;
            end
        end
        check_range("period_1M", 64'(t1 - t0), 100, 101);

        // 25 MHz: Q = 2^30, pattern 0,0,1,1 after clearing the accumulator
        send(32'd25_000_000);
        check("err_25M", Set_Err, 0);
        tick(33);
        check("tw_25M", Tuning_Word, 32'h4000_0000);
        Enable = 1'b0;
        tick(1);
        check("fx_disabled", Fxout, 0);
        Enable = 1'b1;
        pat = 8'b1100_1100;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("pat_25M", Fxout, pat[i]);
        end

        // 50 MHz upper boundary: Q = 2^31, toggles every cycle
        send(32'd50_000_000);
        check("err_50M", Set_Err, 0);
        tick(33);
        check("tw_50M", Tuning_Word, 32'h8000_0000);
        Enable = 1'b0;
        tick(1);
        Enable = 1'b1;
        pat = 8'b1010_1010;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("pat_50M", Fxout, pat[i]);
        end

        // One above the boundary: rejected
        send(32'd50_000_001);
        check("err_pulse", Set_Err, 1);
        check("ready_reject", Set_Ready, 1);
        tick(1);
        check("err_one_cycle", Set_Err, 0);
        check("tw_kept", Tuning_Word, 32'h8000_0000);

        // Valid held through CALC with a new value: taken only once ready
        Freq_Set  = 32'd1_000_000;
        Set_Valid = 1'b1;
        tick(1);
        Freq_Set = 32'd25_000_000;
        check("ready_held", Set_Ready, 0);
        tick(33);
        check("tw_held_first", Tuning_Word, 42_949_672);
        check("ready_held_idle", Set_Ready, 1);
        tick(1);
        Set_Valid = 1'b0;
        check("ready_second", Set_Ready, 0);
        tick(32);
        check("tw_second_load", Tuning_Word, 42_949_672);
        tick(1);
        check("tw_second", Tuning_Word, 32'h4000_0000);

        // Zero frequency: output parks low
        send(32'd0);
        check("err_zero", Set_Err, 0);
        tick(33);
        check("tw_zero", Tuning_Word, 0);
        tick(1);
        check("fx_zero", Fxout, 0);
        tick(5);
        check("fx_zero_stays", Fxout, 0);

        // Reset during CALC cycle 10
        send(32'd25_000_000);
        tick(33);
        check("tw_pre_rst", Tuning_Word, 32'h4000_0000);
        send(32'd1_000_000);
        tick(9);
        check("ready_calc10", Set_Ready, 0);
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
        check("midrst_ready", Set_Ready, 1);
        check("midrst_tw", Tuning_Word, 0);
        check("midrst_fx", Fxout, 0);
        check("midrst_err", Set_Err, 0);
        tick(40);
        check("midrst_discard", Tuning_Word, 0);
        check("midrst_idle", Set_Ready, 1);

        // Short-gate loop-back: 1_234_567 Hz over 10_000 cycles -> 123.46 edges
        send(32'd1_234_567);
        check("err_loop", Set_Err, 0);
        tick(33);
        rises = 0;
        for (int c = 0; c < 10_000; c++) begin
            prev = Fxout;
            tick(1);
            if (!prev && Fxout) rises++;
        end
        check_range("loop_count", 64'(rises), 123, 124);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frequency_generator.md
# frequency_generator

Programmable square-wave source: the transmit-side counterpart of the frequency meter. It accepts a requested frequency in Hz through a valid/ready handshake and converts it to a phase-accumulator tuning word with a sequential divider. It then drives a 50 %-duty-cycle output `Fxout` at that frequency. `Fxout` feeds the meter's `Fxin` for loop-back self-test, or an external pin.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 100_000_000. Frequency of `Clk`. Must be ≥ 2 and < 2^32.
- `ACC_WIDTH`, default 32. Width of the phase accumulator and the tuning word.

Ports:
- `Clk`  in  1  system clock. The only clock.
- `Rst`  in  1  synchronous, active-high reset.
- `Enable`  in  1  1 = accumulator runs; 0 = accumulator and `Fxout` are held at 0.
- `Freq_Set`  in  32  requested frequency in Hz.
- `Set_Valid`  in  1  `Freq_Set` is valid.
- `Set_Ready`  out  1  block can accept a request.
- `Set_Err`  out  1  one-cycle pulse: request rejected.
- `Tuning_Word`  out  ACC_WIDTH  active tuning word.
- `Fxout`  out  1  generated square wave, registered.

## Operation
- Reset values: `Set_Ready`=1, `Set_Err`=0, `Tuning_Word`=0, `Fxout`=0. Accumulator = 0. State = IDLE.
- States:
  - IDLE → CALC on handshake (`Set_Valid` && `Set_Ready`) when `Freq_Set` ≤ `CLK_FREQ_HZ`/2 (integer division).
  - IDLE → IDLE on handshake when `Freq_Set` > `CLK_FREQ_HZ`/2. `Set_Err` pulses the next cycle. `Tuning_Word` is unchanged.
  - CALC → LOAD after exactly ACC_WIDTH iterations.
  - LOAD → IDLE. `Tuning_Word` takes the quotient in this cycle.
- `Set_Ready` = 1 only in IDLE. `Set_Valid` is ignored in every other state; the source holds its request until `Set_Ready`.
- Division: Q = floor(`Freq_Set` · 2^ACC_WIDTH / `CLK_FREQ_HZ`), computed as a restoring division with one quotient bit per cycle, MSB first.
  - Remainder starts at `Freq_Set` and is ACC_WIDTH+1 bits wide.
  - Each iteration: R ← 2R. If R ≥ `CLK_FREQ_HZ`, then R ← R − `CLK_FREQ_HZ` and the quotient bit is 1; otherwise the bit is 0.
  - Because `Freq_Set` ≤ `CLK_FREQ_HZ`/2, Q < 2^(ACC_WIDTH−1) holds, except Q = 2^(ACC_WIDTH−1) exactly at `CLK_FREQ_HZ`/2.
- Accumulator, each cycle with `Enable`=1: acc ← acc + `Tuning_Word` mod 2^ACC_WIDTH. `Fxout` ← acc[ACC_WIDTH−1], sampled before the add.
- Phase continuity: a new tuning word does not reset the accumulator.
- `Tuning_Word` = 0, or `Enable` = 0: acc ← 0 and `Fxout` ← 0 from the next cycle.
- `Freq_Set` = 0 is legal. It loads Q = 0, so `Fxout` goes low and stays low.
- `Rst` dominates every state, including mid-CALC. The partial quotient is discarded and all outputs return to their reset values.

## Timing
- Handshake in cycle n. CALC spans n+1 … n+ACC_WIDTH. LOAD in n+ACC_WIDTH+1. `Tuning_Word` is visible from n+ACC_WIDTH+2. `Set_Ready` is high again in n+ACC_WIDTH+2.
- Rejected request in cycle n: `Set_Err`=1 in n+1 only. `Set_Ready` stays 1 throughout.
- `Fxout` lags the accumulator MSB by one cycle.
- Output period = 2^ACC_WIDTH / Q cycles on average. Edge jitter is ±1 cycle when 2^ACC_WIDTH / Q is not an integer.
- Back-to-back requests: at most one per ACC_WIDTH+2 cycles.

## Structure
- Package `freq_gen_pkg`: state enum `{IDLE, CALC, LOAD}` and a function for `CLK_FREQ_HZ`/2 as a constant.
- Sub-module `tuning_word_divider`: sequential restoring divider.
  - Ports: `Clk`, `Rst`, `start`, `dividend`, `busy`, `done`, `quotient`.
  - The divisor is a parameter.
- The top level holds the FSM, the range check, the accumulator and the `Fxout` register.

## Test plan
- Reset, then `Freq_Set`=1_000_000 (defaults) → `Set_Err`=0; `Tuning_Word`=42_949_672 at handshake+34; `Fxout` period 100 cycles ±1.
- `Freq_Set`=25_000_000 with `Enable`=1 → `Tuning_Word`=1_073_741_824; `Fxout` pattern 0,0,1,1 repeating after reset of the accumulator.
- `Freq_Set`=50_000_000 → `Tuning_Word`=2^31; `Fxout` toggles every cycle. `Freq_Set`=50_000_001 → `Set_Err` pulses one cycle; `Tuning_Word` stays 2^31.
- `Set_Valid` held during CALC with a second value → ignored until `Set_Ready`, then accepted. `Freq_Set`=0 → `Fxout`=0 within 2 cycles of load.
- `Rst` asserted at CALC cycle 10 → next cycle: state IDLE, `Tuning_Word`=0, `Fxout`=0, `Set_Ready`=1.
- Loop-back: `Fxout` into the frequency meter, `Freq_Set`=1_234_567 → measured count within ±1 of 1_234_567 per 1 s gate.
